// File: rtl/store_lane_pkg.sv
// Shared definitions for the store lane unit: size codes, FSM states and
// bus-width derived constants.
package store_lane_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        EXC   = 2'd3
    } state_e;

    // Byte lanes on the bus and the width of the in-bus byte offset.
    function automatic int laneBytes(input int dataW);
        return dataW / 8;
    endfunction

    function automatic int offWidth(input int dataW);
        return $clog2(dataW / 8);
    endfunction

    function automatic int sizeBytes(input logic [1:0] size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// Combinational byte-enable and data lane shifter for one store, spanning two
// bus beats (low half = first beat, high half = second beat).
module lane_mask_gen
    import store_lane_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] addrOff,
    input  logic [1:0]                  size,
    input  logic [DATA_W-1:0]           data,
    output logic [2*(DATA_W/8)-1:0]     mask,
    output logic [2*DATA_W-1:0]         wdata,
    output logic                        misaligned,
    output logic                        crossing,
    output logic                        illegal
);

    localparam int BYTES = laneBytes(DATA_W);
    localparam int OFF_W = offWidth(DATA_W);

    logic [2*BYTES-1:0]  baseMask;
    logic [DATA_W-1:0]   dataTrim;
    logic [2*DATA_W-1:0] dataWide;
    logic [OFF_W-1:0]    offMask;
    int                  nBytes;

    always_comb begin
        nBytes   = sizeBytes(size);
        baseMask = '0;
        dataTrim = '0;
        for (int i = 0; i < 2*BYTES; i++) begin
            if (i < nBytes) baseMask[i] = 1'b1;
        end
        // Bytes above the access size are dropped before shifting.
        for (int i = 0; i < DATA_W; i++) begin
            if ((i / 8) < nBytes) dataTrim[i] = data[i];
        end
        dataWide   = {{DATA_W{1'b0}}, dataTrim};
        mask       = baseMask << addrOff;
        wdata      = dataWide << {addrOff, 3'b000};
        offMask    = OFF_W'(nBytes - 1);
        misaligned = |(addrOff & offMask);
        crossing   = |mask[2*BYTES-1:BYTES];
        illegal    = (size == SIZE_DWORD) && (DATA_W < 64);
    end

endmodule

// File: rtl/store_lane_unit.sv
// Store lane unit: turns a right-aligned store request into one or two
// bus-aligned write beats, or a one-cycle address-error pulse.
module store_lane_unit
    import store_lane_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SPLIT_EN = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic [DATA_W-1:0]   req_data,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_byteen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                exc_ades,
    output logic [ADDR_W-1:0]   exc_addr,
    output state_e              dbgState
);

    localparam int BYTES = laneBytes(DATA_W);
    localparam int OFF_W = offWidth(DATA_W);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Request side is ready only in IDLE; the bus side holds every beat
    // output stable until mem_ready is seen.

    state_e              state;
    logic                crossQ;
    logic [BYTES-1:0]    maskHiQ;
    logic [DATA_W-1:0]   dataHiQ;

    logic [2*BYTES-1:0]  genMask;
    logic [2*DATA_W-1:0] genData;
    logic                genMis;
    logic                genCross;
    logic                genIllegal;
    logic                takeExc;
    logic [ADDR_W-1:0]   alignedAddr;

    lane_mask_gen #(
        .DATA_W (DATA_W)
    ) u_lane_mask_gen (
        .addrOff    (req_addr[OFF_W-1:0]),
        .size       (req_size),
        .data       (req_data),
        .mask       (genMask),
        .wdata      (genData),
        .misaligned (genMis),
        .crossing   (genCross),
        .illegal    (genIllegal)
    );

    assign takeExc     = genIllegal || (genMis && (SPLIT_EN == 0));
    assign alignedAddr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign dbgState    = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_byteen <= '0;
            mem_wdata  <= '0;
            exc_ades   <= 1'b0;
            exc_addr   <= '0;
            crossQ     <= 1'b0;
            maskHiQ    <= '0;
            dataHiQ    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        crossQ    <= genCross;
                        maskHiQ   <= genMask[2*BYTES-1:BYTES];
                        dataHiQ   <= genData[2*DATA_W-1:DATA_W];
                        if (takeExc) begin
                            state    <= EXC;
                            exc_ades <= 1'b1;
                            exc_addr <= req_addr;
                        end else begin
                            state      <= BEAT0;
                            mem_valid  <= 1'b1;
                            mem_addr   <= alignedAddr;
                            mem_byteen <= genMask[BYTES-1:0];
                            mem_wdata  <= genData[DATA_W-1:0];
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        if (crossQ) begin
                            state      <= BEAT1;
                            mem_addr   <= mem_addr + ADDR_W'(BYTES);
                            mem_byteen <= maskHiQ;
                            mem_wdata  <= dataHiQ;
                        end else begin
                            state      <= IDLE;
                            req_ready  <= 1'b1;
                            mem_valid  <= 1'b0;
                            mem_addr   <= '0;
                            mem_byteen <= '0;
                            mem_wdata  <= '0;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        mem_valid  <= 1'b0;
                        mem_addr   <= '0;
                        mem_byteen <= '0;
                        mem_wdata  <= '0;
                    end
                end
                EXC: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    exc_ades  <= 1'b0;
                    exc_addr  <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
